// File: rtl/filter_scan_ctrl.sv
// -----------------------------------------------------------------------------
// filter_scan_ctrl
//
// Sequences one HLS pixel-filter wrapper over a frame_w x frame_h frame. The
// filter has no backpressure on either side, so this block:
//   * holds one fetched pixel together with its (x,y) coordinate,
//   * only starts the filter when the result is guaranteed room downstream,
//   * tracks pixels inside the filter (issued minus written back),
//   * absorbs filter results in a small skid FIFO towards the write-back side.
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   start                   one-cycle frame request (acted on in IDLE only)
//   frame_w, frame_h        frame size, captured together with start
//   busy, done, ovf         frame in progress / completion pulse / sticky drop
//   src_valid, src_ready    input pixel handshake, src_r/g/b pixel data
//   f_posx, f_posy          coordinate of the held pixel
//   f_ready                 filter start
//   f_rden                  filter consumed the held pixel
//   f_in_r/g/b              held pixel towards the filter
//   f_wren, f_out_r/g/b     filter result strobe and data
//   dst_valid, dst_ready    output pixel handshake, dst_r/g/b = FIFO head
// -----------------------------------------------------------------------------
module filter_scan_ctrl #(
  parameter int OUT_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [11:0] frame_w,
  input  logic [11:0] frame_h,
  output logic        busy,
  output logic        done,
  output logic        ovf,
  input  logic        src_valid,
  output logic        src_ready,
  input  logic [7:0]  src_r,
  input  logic [7:0]  src_g,
  input  logic [7:0]  src_b,
  output logic [11:0] f_posx,
  output logic [11:0] f_posy,
  output logic        f_ready,
  input  logic        f_rden,
  output logic [7:0]  f_in_r,
  output logic [7:0]  f_in_g,
  output logic [7:0]  f_in_b,
  input  logic        f_wren,
  input  logic [7:0]  f_out_r,
  input  logic [7:0]  f_out_g,
  input  logic [7:0]  f_out_b,
  output logic        dst_valid,
  input  logic        dst_ready,
  output logic [7:0]  dst_r,
  output logic [7:0]  dst_g,
  output logic [7:0]  dst_b
);

  localparam int AW = $clog2(OUT_DEPTH);
  localparam int CW = AW + 1;  // FIFO occupancy 0..OUT_DEPTH
  localparam int IW = AW + 2;  // in-flight count, headroom for a misbehaving filter
  localparam int OW = AW + 3;  // occupancy + in-flight sum
  localparam logic [CW-1:0] FIFO_FULL_CNT = CW'(OUT_DEPTH);
  localparam logic [OW-1:0] OCC_LIMIT     = OW'(OUT_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_FIN
  } state_t;

  state_t state_reg, state_next;

  // start and the frame size are registered first; the accepted start is the
  // registered one, which gives the zero-size frame its two-cycle DONE latency
  logic        start_reg;
  logic [11:0] start_w_reg;
  logic [11:0] start_h_reg;

  logic [11:0] w_reg;
  logic [23:0] total_reg;
  logic [23:0] fetched_reg;
  logic [23:0] retired_reg;
  logic [11:0] x_reg;
  logic [11:0] y_reg;

  logic        hold_valid_reg;
  logic [7:0]  hold_r_reg, hold_g_reg, hold_b_reg;
  logic [11:0] hold_x_reg, hold_y_reg;

  logic [IW-1:0] inflight_reg;
  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0] fifo_count_reg;
  logic          ovf_reg;

  logic [23:0] fifo_mem [OUT_DEPTH];
  logic [23:0] fifo_head;

  logic          frame_start, frame_ok;
  logic          src_hs, rd_acc, wr_acc;
  logic          fifo_full, push, drop, pop;
  logic [OW-1:0] occupancy;
  logic [23:0]   retired_next;
  logic          x_wrap;

  // ---------------------------------------------------------------------------
  // Handshake and gating decode
  // ---------------------------------------------------------------------------
  assign frame_start = (state_reg == ST_IDLE) && start_reg;
  assign frame_ok    = (start_w_reg != 12'd0) && (start_h_reg != 12'd0);

  assign src_ready = (state_reg == ST_RUN) && (fetched_reg < total_reg)
                     && (!hold_valid_reg || f_rden);
  assign src_hs    = src_valid && src_ready;

  // strobes that do not match our own bookkeeping are ignored
  assign rd_acc = f_rden && hold_valid_reg;
  assign wr_acc = f_wren && (inflight_reg != '0);

  assign fifo_full = (fifo_count_reg == FIFO_FULL_CNT);
  assign push      = wr_acc && !fifo_full;
  assign drop      = wr_acc && fifo_full;
  assign dst_valid = (fifo_count_reg != '0);
  assign pop       = dst_valid && dst_ready;

  // every issued pixel must find a FIFO slot when it comes back
  assign occupancy = OW'(fifo_count_reg) + OW'(inflight_reg);
  assign f_ready   = hold_valid_reg && (occupancy < OCC_LIMIT);

  // a dropped result still retires its pixel so a corrupted frame can end;
  // ovf is what reports the corruption
  assign retired_next = retired_reg + 24'(pop) + 24'(drop);

  assign x_wrap = (x_reg == w_reg - 12'd1);

  assign busy = (state_reg == ST_RUN) || (state_reg == ST_DRAIN);
  assign done = (state_reg == ST_FIN);
  assign ovf  = ovf_reg;

  assign f_posx = hold_x_reg;
  assign f_posy = hold_y_reg;
  assign f_in_r = hold_r_reg;
  assign f_in_g = hold_g_reg;
  assign f_in_b = hold_b_reg;

  // the array is not reset, so the head is masked while the FIFO is empty
  assign fifo_head = fifo_mem[rd_ptr_reg];
  assign dst_r = dst_valid ? fifo_head[23:16] : 8'd0;
  assign dst_g = dst_valid ? fifo_head[15:8]  : 8'd0;
  assign dst_b = dst_valid ? fifo_head[7:0]   : 8'd0;

  // ---------------------------------------------------------------------------
  // Frame FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      ST_IDLE: begin
        if (frame_start) begin
          state_next = frame_ok ? ST_RUN : ST_FIN;
        end
      end
      ST_RUN: begin
        if ((fetched_reg == total_reg) && !hold_valid_reg) begin
          state_next = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // look at the post-pop count so DONE follows the last pop directly
        if (retired_next >= total_reg) begin
          state_next = ST_FIN;
        end
      end
      ST_FIN: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Frame bookkeeping, fetch scan and hold register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_reg      <= 1'b0;
      start_w_reg    <= 12'd0;
      start_h_reg    <= 12'd0;
      w_reg          <= 12'd0;
      total_reg      <= 24'd0;
      fetched_reg    <= 24'd0;
      retired_reg    <= 24'd0;
      x_reg          <= 12'd0;
      y_reg          <= 12'd0;
      hold_valid_reg <= 1'b0;
      hold_r_reg     <= 8'd0;
      hold_g_reg     <= 8'd0;
      hold_b_reg     <= 8'd0;
      hold_x_reg     <= 12'd0;
      hold_y_reg     <= 12'd0;
      ovf_reg        <= 1'b0;
    end else begin
      start_reg   <= start;
      start_w_reg <= frame_w;
      start_h_reg <= frame_h;

      if (frame_start) begin
        w_reg       <= start_w_reg;
        total_reg   <= 24'(start_w_reg) * 24'(start_h_reg);
        fetched_reg <= 24'd0;
        retired_reg <= 24'd0;
        x_reg       <= 12'd0;
        y_reg       <= 12'd0;
      end else begin
        retired_reg <= retired_next;
        if (src_hs) begin
          fetched_reg <= fetched_reg + 24'd1;
          x_reg       <= x_wrap ? 12'd0 : x_reg + 12'd1;
          if (x_wrap) begin
            y_reg <= y_reg + 12'd1;
          end
        end
      end

      // a reload in the same cycle as consumption keeps the register full
      hold_valid_reg <= src_hs || (hold_valid_reg && !rd_acc);
      if (src_hs) begin
        hold_r_reg <= src_r;
        hold_g_reg <= src_g;
        hold_b_reg <= src_b;
        hold_x_reg <= x_reg;
        hold_y_reg <= y_reg;
      end

      if (frame_start) begin
        ovf_reg <= 1'b0;
      end else if (drop) begin
        ovf_reg <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // In-flight counter and output skid FIFO
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight_reg   <= '0;
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      fifo_count_reg <= '0;
    end else begin
      inflight_reg <= inflight_reg + IW'(rd_acc) - IW'(wr_acc);
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      unique case ({push, pop})
        2'b10:   fifo_count_reg <= fifo_count_reg + CW'(1);
        2'b01:   fifo_count_reg <= fifo_count_reg - CW'(1);
        default: fifo_count_reg <= fifo_count_reg;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_reg] <= {f_out_r, f_out_g, f_out_b};
    end
  end

endmodule

// File: tb/tb_filter_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_filter_scan_ctrl
//
// Directed bench for filter_scan_ctrl. A two-cycle gray filter model sits on
// the filter side; source pixels follow a fixed formula so the expected gray
// value and coordinate of every pixel is known by index.
// -----------------------------------------------------------------------------
module tb_filter_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [11:0] frame_w, frame_h;
  logic        busy, done, ovf;
  logic        src_valid, src_ready;
  logic [7:0]  src_r, src_g, src_b;
  logic [11:0] f_posx, f_posy;
  logic        f_ready, f_rden;
  logic [7:0]  f_in_r, f_in_g, f_in_b;
  logic        f_wren;
  logic [7:0]  f_out_r, f_out_g, f_out_b;
  logic        dst_valid, dst_ready;
  logic [7:0]  dst_r, dst_g, dst_b;

  logic        rogue_rden;
  int          src_mode;     // 0 idle, 1 always valid, 2 random valid
  int          cur_w;
  int          src_idx, issue_idx, out_idx, done_cnt, srdy_seen;
  int          cyc, last_hs_cyc, done_cyc;
  int          checks, errors;

  always #5 clk = ~clk;

  filter_scan_ctrl #(.OUT_DEPTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .frame_w(frame_w), .frame_h(frame_h),
    .busy(busy), .done(done), .ovf(ovf),
    .src_valid(src_valid), .src_ready(src_ready),
    .src_r(src_r), .src_g(src_g), .src_b(src_b),
    .f_posx(f_posx), .f_posy(f_posy), .f_ready(f_ready), .f_rden(f_rden),
    .f_in_r(f_in_r), .f_in_g(f_in_g), .f_in_b(f_in_b),
    .f_wren(f_wren), .f_out_r(f_out_r), .f_out_g(f_out_g), .f_out_b(f_out_b),
    .dst_valid(dst_valid), .dst_ready(dst_ready),
    .dst_r(dst_r), .dst_g(dst_g), .dst_b(dst_b)
  );

  function automatic logic [7:0] gray(input logic [7:0] r, input logic [7:0] g,
                                      input logic [7:0] b);
    logic [9:0] s;
    s = {2'b00, r} + {1'b0, g, 1'b0} + {2'b00, b};
    return s[9:2];
  endfunction

  function automatic logic [23:0] pix(input int i);
    logic [7:0] r, g, b;
    r = 8'(i * 7 + 3);
    g = 8'(i * 13 + 40);
    b = 8'(200 - i * 5);
    return {r, g, b};
  endfunction

  function automatic logic [23:0] exp_out(input int i);
    logic [23:0] p;
    logic [7:0]  gv;
    p  = pix(i);
    gv = gray(p[23:16], p[15:8], p[7:0]);
    return {gv, gv, gv};
  endfunction

  // model filter: consumes on f_rden, writes the gray value back two cycles later
  logic       s1_v, s2_v;
  logic [7:0] s1_d, s2_d;
  assign f_rden  = f_ready | rogue_rden;
  assign f_wren  = s2_v;
  assign f_out_r = s2_d;
  assign f_out_g = s2_d;
  assign f_out_b = s2_d;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v <= 1'b0; s2_v <= 1'b0; s1_d <= 8'd0; s2_d <= 8'd0;
    end else begin
      s1_v <= f_rden;
      s1_d <= gray(f_in_r, f_in_g, f_in_b);
      s2_v <= s1_v;
      s2_d <= s1_d;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // one clock: sample at the falling edge, drive #1 after the rising edge
  task automatic cycle();
    @(negedge clk);
    if (src_valid && src_ready) src_idx++;
    if (f_rden) begin
      check("posx", 64'(f_posx), 64'(issue_idx % cur_w));
      check("posy", 64'(f_posy), 64'(issue_idx / cur_w));
      issue_idx++;
    end
    if (dst_valid && dst_ready) begin
      check("dst_pix", 64'({dst_r, dst_g, dst_b}), 64'(exp_out(out_idx)));
      $display("dst px %0d data %06h", out_idx, {dst_r, dst_g, dst_b});
      out_idx++;
      last_hs_cyc = cyc;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (src_ready) srdy_seen++;
    @(posedge clk);
    #1;
    cyc++;
    src_valid = (src_mode == 1) ? 1'b1 : (src_mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
    {src_r, src_g, src_b} = pix(src_idx);
  endtask

  task automatic clear_frame_stats(input int w);
    cur_w = w; src_idx = 0; issue_idx = 0; out_idx = 0;
    done_cnt = 0; srdy_seen = 0; last_hs_cyc = -10; done_cyc = -20;
  endtask

  task automatic start_frame(input int w, input int h);
    clear_frame_stats(w);
    start = 1'b1; frame_w = 12'(w); frame_h = 12'(h);
    cycle();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (done_cnt == 0 && n < budget) begin
      cycle();
      n++;
    end
    check("done_within_budget", 64'(done_cnt != 0), 64'd1);
  endtask

  task automatic check_frame_end(input string tag, input int npix);
    check({tag, "_out_count"}, 64'(out_idx), 64'(npix));
    check({tag, "_done_once"}, 64'(done_cnt), 64'd1);
    check({tag, "_done_after_last"}, 64'(done_cyc - last_hs_cyc), 64'd1);
    cycle();
    check({tag, "_busy_after"}, 64'(busy), 64'd0);
    check({tag, "_done_cleared"}, 64'(done_cnt), 64'd1);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_done"}, 64'(done), 64'd0);
    check({tag, "_ovf"}, 64'(ovf), 64'd0);
    check({tag, "_src_ready"}, 64'(src_ready), 64'd0);
    check({tag, "_f_ready"}, 64'(f_ready), 64'd0);
    check({tag, "_dst_valid"}, 64'(dst_valid), 64'd0);
    check({tag, "_f_pos"}, 64'({f_posx, f_posy}), 64'd0);
    check({tag, "_f_in"}, 64'({f_in_r, f_in_g, f_in_b}), 64'd0);
    check({tag, "_dst_data"}, 64'({dst_r, dst_g, dst_b}), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    checks = 0; errors = 0; cyc = 0;
    rst_n = 1'b0; start = 1'b0; frame_w = 12'd0; frame_h = 12'd0;
    src_valid = 1'b0; {src_r, src_g, src_b} = 24'd0;
    dst_ready = 1'b1; rogue_rden = 1'b0; src_mode = 0;
    clear_frame_stats(1);

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("rst");
    rst_n = 1'b1;
    cycle();
    check_outputs_zero("post_rst");

    // reset in the middle of a running frame
    src_mode = 1; dst_ready = 1'b1;
    start_frame(4, 2);
    for (int n = 0; n < 50 && issue_idx < 3; n++) cycle();
    check("midrst_issued", 64'(issue_idx), 64'd3);
    check("midrst_busy_before", 64'(busy), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_outputs_zero("midrst");
    check("midrst_no_done", 64'(done_cnt), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cycle();

    // clean 4x2 frame, always-valid source, ready sink
    start_frame(4, 2);
    wait_done(200);
    check_frame_end("f4x2", 8);
    check("f4x2_ovf", 64'(ovf), 64'd0);

    // 3x3 with the sink stalled for 40 cycles
    dst_ready = 1'b0;
    start_frame(3, 3);
    repeat (40) cycle();
    check("stall_issued", 64'(issue_idx), 64'd8);
    check("stall_f_ready", 64'(f_ready), 64'd0);
    check("stall_dst_valid", 64'(dst_valid), 64'd1);
    check("stall_ovf", 64'(ovf), 64'd0);
    check("stall_no_out", 64'(out_idx), 64'd0);
    dst_ready = 1'b1;
    wait_done(200);
    check_frame_end("stall", 9);
    check("stall_ovf_end", 64'(ovf), 64'd0);

    // zero-width frame
    src_mode = 1;
    clear_frame_stats(1);
    start = 1'b1; frame_w = 12'd0; frame_h = 12'd5;
    cycle();
    start = 1'b0;
    check("zero_done_c1", 64'(done), 64'd0);
    cycle();
    check("zero_done_c2", 64'(done), 64'd1);
    check("zero_busy_c2", 64'(busy), 64'd0);
    cycle();
    check("zero_done_c3", 64'(done), 64'd0);
    repeat (3) cycle();
    check("zero_no_src_ready", 64'(srdy_seen), 64'd0);
    check("zero_done_once", 64'(done_cnt), 64'd1);

    // filter ignores the gate: result written back into a full FIFO
    dst_ready = 1'b0;
    start_frame(3, 3);
    repeat (30) cycle();
    check("ovf_before", 64'(ovf), 64'd0);
    check("ovf_held", 64'(issue_idx), 64'd8);
    rogue_rden = 1'b1;
    cycle();
    rogue_rden = 1'b0;
    repeat (4) cycle();
    check("ovf_set", 64'(ovf), 64'd1);
    dst_ready = 1'b1;
    wait_done(200);
    check("ovf_out_count", 64'(out_idx), 64'd8);
    check("ovf_sticky", 64'(ovf), 64'd1);
    repeat (3) cycle();
    check("ovf_sticky_idle", 64'(ovf), 64'd1);
    start_frame(4, 2);
    cycle();
    check("ovf_cleared", 64'(ovf), 64'd0);
    wait_done(200);
    check_frame_end("after_ovf", 8);

    // random source valid, START pulsed mid-frame with a different size
    src_mode = 2;
    start_frame(4, 3);
    repeat (6) cycle();
    start = 1'b1; frame_w = 12'd2; frame_h = 12'd2;
    cycle();
    start = 1'b0;
    repeat (5) cycle();
    check("midstart_busy", 64'(busy), 64'd1);
    wait_done(400);
    check_frame_end("rand", 12);
    check("rand_issued", 64'(issue_idx), 64'd12);
    src_mode = 0;
    repeat (4) cycle();
    check("final_idle_done", 64'(done_cnt), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
